seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scan controller for the board's common-anode seven-segment display. It shares one set of segment lines between NUM_DIGITS digits by stepping a digit index that steers the segment multiplexer, driving one anode at a time, and inserting a dead-time blank between digits to suppress ghosting. It sits between the value-producing logic (counters, BCD converters) and the display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 500: dead-time cycles at the start of each slot; legal range 1..REFRESH_DIV-1.
- clk, in, 1: system clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- en, in, 1: scan enable; 0 forces the display dark.
- digits, in, 4*NUM_DIGITS: hex nibble per digit; digit i is bits [4i+3:4i].
- dp, in, NUM_DIGITS: decimal point request per digit, active-high.
- blank_mask, in, NUM_DIGITS: 1 means digit i stays dark (leading-zero suppression).
- an, out, NUM_DIGITS: anode enables, active-low.
- seg, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp_n, out, 1: decimal point, active-low.
- digit_idx, out, $clog2(NUM_DIGITS): index of the digit currently owning the segment lines.
- frame_tick, out, 1: one-cycle pulse when a new frame begins at digit 0.

## Operation
- States: IDLE, BLANK, SHOW. Slot counter cnt counts 0..REFRESH_DIV-1.
- Reset sets: state IDLE, cnt 0, digit_idx 0, an all 1, seg 7'h7F, dp_n 1, frame_tick 0, snapshot 0.
- IDLE: the block leaves IDLE when en=1. On that edge it enters BLANK with cnt=0 and digit_idx=0. It also captures the snapshot (digits, dp, blank_mask) and pulses frame_tick.
- BLANK: outputs dark while cnt < BLANK_CYCLES. The block moves to SHOW when cnt reaches BLANK_CYCLES.
- SHOW: an[digit_idx]=0 and all other an bits are 1. seg is the decoded snapshot nibble of digit_idx, and dp_n = ~snapshot dp[digit_idx].
  - If the snapshot blank_mask[digit_idx]=1, an stays all 1, seg stays 7'h7F and dp_n stays 1 for the whole slot.
- End of slot (cnt=REFRESH_DIV-1): cnt becomes 0, the state returns to BLANK, and digit_idx increments.
  - When digit_idx wraps from NUM_DIGITS-1 to 0, the block recaptures the snapshot and pulses frame_tick.
- Snapshot: digit content only changes at frame boundaries, so there is no mid-frame tearing.
- en=0 in any non-IDLE state: on the next edge the block goes to IDLE. Outputs go dark, cnt returns to 0 and digit_idx returns to 0. No partial slot completes.
- en re-asserted: the scan restarts from digit 0 with a fresh snapshot.
- Decode: standard hex font 0-F, for example 0→7'h40, 8→7'h00, F→7'h0E.

## Timing
- Outputs (an, seg, dp_n, digit_idx, frame_tick) are flops loaded with next-state values, so they change on the same edge as the state.
- There is no combinational path from any input to any output.
- Input latency: a change on digits, dp or blank_mask reaches the pins at the next frame boundary, after at most NUM_DIGITS*REFRESH_DIV+1 cycles.
- Per slot: BLANK_CYCLES cycles dark, then REFRESH_DIV-BLANK_CYCLES cycles lit. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_tick is high for exactly one cycle per frame, coincident with the first BLANK cycle of digit 0.
- An rst_n assertion mid-slot drives all outputs to their reset values immediately, without waiting for a clock edge.
- Deassertion is synchronised externally; the first active edge after rst_n rises may already leave IDLE if en=1.

## Structure
- Shared header seg7_defs.vh holds:
  - state encodings (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2);
  - SEG_OFF=7'h7F;
  - the hex font constants.
- One sub-module, hex_to_seg7: purely combinational, 4-bit nibble in, 7-bit active-low pattern out. The digit selection feeding it reuses the team's mux primitives.
- The controller owns the FSM, the slot counter, the index, the snapshot registers and the output flops.

## Test plan
Tests run with NUM_DIGITS=4, REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset, then en=1 and digits=16'h1234:
  - an is 4'b1111 for 2 cycles, then 4'b1110 with seg=7'h19 ("4") for 6 cycles;
  - then 2 dark cycles, then 4'b1101 with "3";
  - frame_tick pulses every 32 cycles.
- Change digits mid-frame: pins keep the old values until the next frame_tick, then show the new values.
- blank_mask=4'b1000 with digits=16'h0042: during slot 3, an=4'b1111 and seg=7'h7F; the other slots are lit normally.
- dp=4'b0010: dp_n=0 only during the SHOW phase of digit 1.
- en drops during the SHOW phase of digit 2:
  - next edge gives an=4'b1111, digit_idx=0, frame_tick=0;
  - re-enable restarts at digit 0 with BLANK.
- Assert rst_n asynchronously mid-SHOW: an, seg and dp_n go dark before the next clock edge, and all other outputs go to their reset values.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_e : controller state encoding (IDLE / BLANK / SHOW)
//   - SEG_OFF      : active-low "all segments dark" pattern
//   - FONT_*       : active-low hex font, bit order {g,f,e,d,c,b,a}
//   - hex_font()   : nibble -> font pattern lookup
// ---------------------------------------------------------------------------
package seg7_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] FONT_0 = 7'h40;
   localparam logic [6:0] FONT_1 = 7'h79;
   localparam logic [6:0] FONT_2 = 7'h24;
   localparam logic [6:0] FONT_3 = 7'h30;
   localparam logic [6:0] FONT_4 = 7'h19;
   localparam logic [6:0] FONT_5 = 7'h12;
   localparam logic [6:0] FONT_6 = 7'h02;
   localparam logic [6:0] FONT_7 = 7'h78;
   localparam logic [6:0] FONT_8 = 7'h00;
   localparam logic [6:0] FONT_9 = 7'h10;
   localparam logic [6:0] FONT_A = 7'h08;
   localparam logic [6:0] FONT_B = 7'h03;
   localparam logic [6:0] FONT_C = 7'h46;
   localparam logic [6:0] FONT_D = 7'h21;
   localparam logic [6:0] FONT_E = 7'h06;
   localparam logic [6:0] FONT_F = 7'h0E;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = FONT_0;
         4'h1:    pat = FONT_1;
         4'h2:    pat = FONT_2;
         4'h3:    pat = FONT_3;
         4'h4:    pat = FONT_4;
         4'h5:    pat = FONT_5;
         4'h6:    pat = FONT_6;
         4'h7:    pat = FONT_7;
         4'h8:    pat = FONT_8;
         4'h9:    pat = FONT_9;
         4'hA:    pat = FONT_A;
         4'hB:    pat = FONT_B;
         4'hC:    pat = FONT_C;
         4'hD:    pat = FONT_D;
         4'hE:    pat = FONT_E;
         4'hF:    pat = FONT_F;
         default: pat = SEG_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex-to-seven-segment decoder (common anode).
// Ports:
//   nibble  in  4  hex value to display
//   pattern out 7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg7
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   // Font lookup for the selected nibble
   always_comb begin
      pattern = hex_font(nibble);
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Each digit gets a slot of REFRESH_DIV cycles: BLANK_CYCLES dark cycles
// (ghosting suppression) followed by the lit phase. Digit content is taken
// from a snapshot captured only at frame start, so a frame never tears.
// Ports:
//   clk        in  1             system clock, rising edge
//   rst_n      in  1             asynchronous active-low reset
//   en         in  1             scan enable, 0 forces the display dark
//   digits     in  4*NUM_DIGITS  hex nibble per digit, digit i at [4i+3:4i]
//   dp         in  NUM_DIGITS    decimal point request per digit
//   blank_mask in  NUM_DIGITS    1 keeps digit i dark for its whole slot
//   an         out NUM_DIGITS    anode enables, active-low
//   seg        out 7             segments {g,f,e,d,c,b,a}, active-low
//   dp_n       out 1             decimal point, active-low
//   digit_idx  out clog2(N)      digit currently owning the segment lines
//   frame_tick out 1             one-cycle pulse at the first cycle of a frame
// All outputs are flops loaded from next-state values.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [4*NUM_DIGITS-1:0]       digits,
   input  logic [NUM_DIGITS-1:0]         dp,
   input  logic [NUM_DIGITS-1:0]         blank_mask,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seg,
   output logic                          dp_n,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(REFRESH_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   // Counter value whose successor is the first lit cycle of the slot
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};

   scan_state_e                state_r;
   scan_state_e                state_s;
   logic [CNT_W-1:0]           cnt_r;
   logic [CNT_W-1:0]           cnt_s;
   logic [IDX_W-1:0]           idx_r;
   logic [IDX_W-1:0]           idx_s;
   logic [4*NUM_DIGITS-1:0]    snap_digits_r;
   logic [4*NUM_DIGITS-1:0]    snap_digits_s;
   logic [NUM_DIGITS-1:0]      snap_dp_r;
   logic [NUM_DIGITS-1:0]      snap_dp_s;
   logic [NUM_DIGITS-1:0]      snap_mask_r;
   logic [NUM_DIGITS-1:0]      snap_mask_s;
   logic                       capture_s;

   logic [3:0]                 sel_nib_s;
   logic [6:0]                 font_s;

   logic [NUM_DIGITS-1:0]      an_r;
   logic [NUM_DIGITS-1:0]      an_s;
   logic [6:0]                 seg_r;
   logic [6:0]                 seg_s;
   logic                       dp_n_r;
   logic                       dp_n_s;
   logic                       tick_r;

   // Next-state logic: FSM, slot counter, digit index and snapshot capture
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      idx_s         = idx_r;
      capture_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (en) begin
               state_s   = BLANK;
               cnt_s     = {CNT_W{1'b0}};
               idx_s     = {IDX_W{1'b0}};
               capture_s = 1'b1;
            end else begin
               state_s   = IDLE;
            end
         end
         BLANK, SHOW: begin
            if (!en) begin
               // Abandon the slot immediately; no partial slot completes
               state_s = IDLE;
               cnt_s   = {CNT_W{1'b0}};
               idx_s   = {IDX_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               state_s = BLANK;
               cnt_s   = {CNT_W{1'b0}};
               if (idx_r == IDX_LAST) begin
                  // Frame boundary: new content is only taken here
                  idx_s     = {IDX_W{1'b0}};
                  capture_s = 1'b1;
               end else begin
                  idx_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_BLANK_LAST) begin
                  state_s = SHOW;
               end else begin
                  state_s = state_r;
               end
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
         end
      endcase

      if (capture_s) begin
         snap_digits_s = digits;
         snap_dp_s     = dp;
         snap_mask_s   = blank_mask;
      end else begin
         snap_digits_s = snap_digits_r;
         snap_dp_s     = snap_dp_r;
         snap_mask_s   = snap_mask_r;
      end
   end

   // Digit multiplexer: nibble of the next-cycle digit from the next snapshot
   always_comb begin
      sel_nib_s = snap_digits_s[{idx_s, 2'b00} +: 4];
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble  (sel_nib_s),
      .pattern (font_s)
   );

   // Output pre-computation from next-state values so the pins are pure flops
   always_comb begin
      an_s   = AN_OFF;
      seg_s  = SEG_OFF;
      dp_n_s = 1'b1;
      if ((state_s == SHOW) && !snap_mask_s[idx_s]) begin
         an_s   = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_s);
         seg_s  = font_s;
         dp_n_s = ~snap_dp_s[idx_s];
      end else begin
         an_s   = AN_OFF;
         seg_s  = SEG_OFF;
         dp_n_s = 1'b1;
      end
   end

   // State, counter, index and snapshot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         idx_r         <= {IDX_W{1'b0}};
         snap_digits_r <= {(4*NUM_DIGITS){1'b0}};
         snap_dp_r     <= {NUM_DIGITS{1'b0}};
         snap_mask_r   <= {NUM_DIGITS{1'b0}};
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         idx_r         <= idx_s;
         snap_digits_r <= snap_digits_s;
         snap_dp_r     <= snap_dp_s;
         snap_mask_r   <= snap_mask_s;
      end
   end

   // Registered display outputs and frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r   <= AN_OFF;
         seg_r  <= SEG_OFF;
         dp_n_r <= 1'b1;
         tick_r <= 1'b0;
      end else begin
         an_r   <= an_s;
         seg_r  <= seg_s;
         dp_n_r <= dp_n_s;
         tick_r <= capture_s;
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign dp_n       = dp_n_r;
   assign digit_idx  = idx_r;
   assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl (N=4, REFRESH_DIV=8, BLANK=2).
// The reference model tracks only "cycles since the scan started" and derives
// slot, phase and frame with plain division/modulo; content is a snapshot of
// the inputs taken whenever that count hits a frame multiple.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int R     = 8;
   localparam int B     = 2;
   localparam int FRAME = N * R;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [15:0]   digits;
   logic [3:0]    dp;
   logic [3:0]    blank_mask;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          dp_n;
   logic [1:0]    digit_idx;
   logic          frame_tick;

   int n_cmp;
   int n_bad;

   // reference model state
   logic          m_active;
   int            m_t;
   logic [15:0]   m_digits;
   logic [3:0]    m_dp;
   logic [3:0]    m_mask;

   logic [6:0] font_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .digits     (digits),
      .dp         (dp),
      .blank_mask (blank_mask),
      .an         (an),
      .seg        (seg),
      .dp_n       (dp_n),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string tag, input string what, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s %s: got %h expected %h (t=%0d)", tag, what, got, exp, m_t);
      end
   endtask

   function automatic int m_slot();
      return (m_t / R) % N;
   endfunction

   function automatic int m_phase();
      return m_t % R;
   endfunction

   task automatic check_outputs(input string tag);
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp_n;
      logic [1:0] exp_idx;
      logic       exp_tick;
      int         slot;
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      exp_dp_n = 1'b1;
      exp_idx  = 2'd0;
      exp_tick = 1'b0;
      if (m_active) begin
         slot     = m_slot();
         exp_idx  = 2'(slot);
         exp_tick = (m_t % FRAME == 0) ? 1'b1 : 1'b0;
         if ((m_phase() >= B) && !m_mask[slot]) begin
            exp_an   = ~(4'b0001 << slot);
            exp_seg  = font_tbl[m_digits[slot*4 +: 4]];
            exp_dp_n = ~m_dp[slot];
         end
      end
      cmp(tag, "an", 16'(an), 16'(exp_an));
      cmp(tag, "seg", 16'(seg), 16'(exp_seg));
      cmp(tag, "dp_n", 16'(dp_n), 16'(exp_dp_n));
      cmp(tag, "digit_idx", 16'(digit_idx), 16'(exp_idx));
      cmp(tag, "frame_tick", 16'(frame_tick), 16'(exp_tick));
   endtask

   task automatic capture();
      m_digits = digits;
      m_dp     = dp;
      m_mask   = blank_mask;
   endtask

   // one clock: advance the model with the inputs seen at the edge, then check
   task automatic cycle(input string tag);
      @(posedge clk);
      if (!en) begin
         m_active = 1'b0;
         m_t      = 0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_t      = 0;
         capture();
      end else begin
         m_t++;
         if (m_t % FRAME == 0) capture();
      end
      #1;
      check_outputs(tag);
   endtask

   // advance until the model is in the lit part of the given slot (bounded)
   task automatic wait_lit(input int want, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (m_active && (m_slot() == want) && (m_phase() >= B + 1)) begin
            found = 1'b1;
            break;
         end
         cycle(tag);
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: lit phase of slot %0d not reached within budget", tag, want);
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      m_active   = 1'b0;
      m_t        = 0;
      m_digits   = 16'h0000;
      m_dp       = 4'h0;
      m_mask     = 4'h0;
      rst_n      = 1'b0;
      en         = 1'b0;
      digits     = 16'h0000;
      dp         = 4'h0;
      blank_mask = 4'h0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      rst_n = 1'b1;
      cycle("idle");

      // basic scan of 16'h1234
      en     = 1'b1;
      digits = 16'h1234;
      cycle("start");
      cmp("start", "frame_tick_first", 16'(frame_tick), 16'h1);
      cmp("start", "an_dark_first", 16'(an), 16'hF);
      cycle("blank2");
      cycle("lit0");
      cmp("lit0", "an_digit0", 16'(an), 16'hE);
      cmp("lit0", "seg_four", 16'(seg), 16'h19);
      repeat (8) cycle("scan");
      cmp("lit1", "an_digit1", 16'(an), 16'hD);
      cmp("lit1", "seg_three", 16'(seg), 16'h30);
      repeat (30) cycle("scan");

      // mid-frame content change: visible only from the next frame
      digits = 16'hABCD;
      repeat (40) cycle("midframe");

      // leading-zero suppression on digit 3
      blank_mask = 4'b1000;
      digits     = 16'h0042;
      repeat (2 * FRAME) cycle("mask");

      // decimal point on digit 1 only
      blank_mask = 4'b0000;
      dp         = 4'b0010;
      repeat (40) cycle("dp");

      // enable drop in SHOW of digit 2, then restart
      wait_lit(2, "to_show2");
      en = 1'b0;
      cycle("en_drop");
      cmp("en_drop", "an_off", 16'(an), 16'hF);
      cmp("en_drop", "idx_zero", 16'(digit_idx), 16'h0);
      cmp("en_drop", "tick_low", 16'(frame_tick), 16'h0);
      en = 1'b1;
      cycle("restart");
      cmp("restart", "tick", 16'(frame_tick), 16'h1);
      repeat (20) cycle("restart");

      // randomized inputs with occasional enable drops
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 5) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
         if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom);
         en = ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0;
         cycle("rand");
      end
      en = 1'b1;
      blank_mask = 4'b0000;
      repeat (FRAME) cycle("settle");

      // asynchronous reset in the middle of a lit phase
      wait_lit(1, "to_show1");
      #2;
      rst_n = 1'b0;
      #1;
      m_active = 1'b0;
      m_t      = 0;
      check_outputs("async_rst");
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b1;
      cycle("post_rst_idle");
      en = 1'b1;
      repeat (40) cycle("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
